// File: rtl/ppu_fifo_writer_if.sv
// ppu_fifo_writer_if: PPU pixel stream plus FIFO write-side handshake
interface ppu_fifo_writer_if #(parameter int W = 6);
  logic frame_start, pix_valid, pix_ready, fifo_full, fifo_we;
  logic [W-1:0] pix_data, fifo_data;
  modport master(output frame_start, pix_valid, pix_data, fifo_full, input pix_ready, fifo_we, fifo_data);
  modport slave(input frame_start, pix_valid, pix_data, fifo_full, output pix_ready, fifo_we, fifo_data);
endinterface

// File: rtl/ppu_fifo_writer.sv
// ppu_fifo_writer: frame-aligned PPU pixel producer with skid buffer into the crossing FIFO
module ppu_fifo_writer #(
  parameter int W = 6,
  parameter int H_PIX = 256,
  parameter int V_LINES = 240,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W = 16
) (
  input  logic             w_clk,
  input  logic             reset,
  ppu_fifo_writer_if.slave bus,
  output logic             frame_done,
  output logic             frame_err,
  output logic             sync_lost,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int XW = H_PIX > 1 ? $clog2(H_PIX) : 1;
  localparam int YW = V_LINES > 1 ? $clog2(V_LINES) : 1;
  typedef enum logic [1:0] {ALIGN, STREAM, RESYNC} state_t;
  state_t state_q, state_d;
  logic out_v_q, out_v_d, sk_v_q, sk_v_d, rdy_q, rdy_d, done_q, done_d, err_q, err_d;
  logic [W-1:0] out_q, out_d, sk_q, sk_d;
  logic [XW-1:0] x_q, x_d, px;
  logic [YW-1:0] y_q, y_d, py;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic accept, drain, out_free, want, ovf, push, p0, x_end, y_end, drop;
  always_comb begin
    accept = bus.pix_valid & rdy_q;
    drain = out_v_q & ~bus.fifo_full;
    out_free = ~out_v_q | drain;
    want = accept & (state_q == STREAM | bus.frame_start);
    ovf = want & ~out_free & sk_v_q;
    push = want & ~ovf;
    // a frame_start pixel, or the first pixel after alignment, is always (0,0)
    p0 = bus.frame_start | state_q != STREAM;
    px = p0 ? '0 : x_q;
    py = p0 ? '0 : y_q;
    x_end = px == XW'(H_PIX - 1);
    y_end = py == YW'(V_LINES - 1);
    out_v_d = out_free ? sk_v_q | push : 1'b1;
    out_d = out_free & sk_v_q ? sk_q : out_free & push ? bus.pix_data : out_q;
    sk_v_d = out_free ? sk_v_q & push : sk_v_q | push;
    sk_d = push & (sk_v_q | ~out_free) ? bus.pix_data : sk_q;
    rdy_d = DROP_ON_FULL != 0 | ~sk_v_d;
    x_d = push ? (x_end ? '0 : px + 1'b1) : x_q;
    y_d = push & x_end ? (y_end ? '0 : py + 1'b1) : push ? py : y_q;
    done_d = push & x_end & y_end;
    err_d = err_q | (accept & state_q == STREAM & (bus.frame_start != (x_q == '0 & y_q == '0)));
    drop = ovf | (accept & state_q == RESYNC & ~bus.frame_start);
    drop_d = drop & ~&drop_q ? drop_q + 1'b1 : drop_q;
    state_d = ovf ? RESYNC : push ? STREAM : state_q;
  end
  always_ff @(posedge w_clk or posedge reset)
    if (reset) begin
      state_q <= ALIGN;
      out_v_q <= 1'b0;
      sk_v_q <= 1'b0;
      rdy_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
      out_q <= '0;
      sk_q <= '0;
      x_q <= '0;
      y_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      out_v_q <= out_v_d;
      sk_v_q <= sk_v_d;
      rdy_q <= rdy_d;
      done_q <= done_d;
      err_q <= err_d;
      out_q <= out_d;
      sk_q <= sk_d;
      x_q <= x_d;
      y_q <= y_d;
      drop_q <= drop_d;
    end
  assign bus.pix_ready = rdy_q;
  assign bus.fifo_we = out_v_q;
  assign bus.fifo_data = out_q;
  assign frame_done = done_q;
  assign frame_err = err_q;
  assign sync_lost = state_q == RESYNC;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_ppu_fifo_writer.sv
// tb_ppu_fifo_writer: random and directed streams into a backpressure and a drop-on-full instance
module tb_ppu_fifo_writer;
  localparam int W = 6, H = 4, V = 2, N = H * V, CW1 = 4;
  logic w_clk = 0, reset = 1;
  always #5 w_clk = ~w_clk;
  ppu_fifo_writer_if #(W) a(), b();
  logic iv[2], ifs[2], ifull[2];
  logic [W-1:0] id[2];
  logic fd0, fd1, fe0, fe1, sl0, sl1;
  logic [15:0] dc0;
  logic [CW1-1:0] dc1;
  assign a.pix_valid = iv[0];
  assign a.frame_start = ifs[0];
  assign a.pix_data = id[0];
  assign a.fifo_full = ifull[0];
  assign b.pix_valid = iv[1];
  assign b.frame_start = ifs[1];
  assign b.pix_data = id[1];
  assign b.fifo_full = ifull[1];
  ppu_fifo_writer #(.W(W), .H_PIX(H), .V_LINES(V), .DROP_ON_FULL(0), .CNT_W(16)) u0 (
    .w_clk(w_clk), .reset(reset), .bus(a.slave), .frame_done(fd0), .frame_err(fe0), .sync_lost(sl0), .drop_cnt(dc0));
  ppu_fifo_writer #(.W(W), .H_PIX(H), .V_LINES(V), .DROP_ON_FULL(1), .CNT_W(CW1)) u1 (
    .w_clk(w_clk), .reset(reset), .bus(b.slave), .frame_done(fd1), .frame_err(fe1), .sync_lost(sl1), .drop_cnt(dc1));
  int n_chk = 0, n_err = 0;
  int q0[$], q1[$];
  int st[2], idx[2], err[2], drop[2], done[2], g[2];
  bit acc[2];
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int qsize(int m);
    return m ? q1.size() : q0.size();
  endfunction
  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; idx[m] = 0; err[m] = 0; drop[m] = 0; done[m] = 0; g[m] = 0; iv[m] = 0; acc[m] = 0;
    end
  endtask
  // pipeline seen as an ordered queue of at most two pixels; frame position as a linear index
  task automatic model(int m);
    int sz, p;
    bit rdy, drn, want, ovf;
    sz = qsize(m);
    rdy = m == 1 || sz < 2;
    drn = sz > 0 && !ifull[m];
    acc[m] = iv[m] && rdy;
    done[m] = 0;
    if (drn) begin
      if (m) void'(q1.pop_front()); else void'(q0.pop_front());
    end
    if (acc[m]) begin
      want = st[m] == 1 || ifs[m];
      ovf = want && sz == 2 && !drn;
      if (st[m] == 1 && (ifs[m] != (idx[m] == 0))) err[m] = 1;
      p = (ifs[m] || st[m] != 1) ? 0 : idx[m];
      if (ovf) begin
        drop[m] = drop[m] + (drop[m] < (m ? 15 : 65535) ? 1 : 0);
        st[m] = 2;
      end else if (want) begin
        if (m) q1.push_back(int'(id[m])); else q0.push_back(int'(id[m]));
        st[m] = 1;
        idx[m] = (p + 1) % N;
        done[m] = p == N - 1;
      end else if (st[m] == 2)
        drop[m] = drop[m] + (drop[m] < (m ? 15 : 65535) ? 1 : 0);
    end
  endtask
  task automatic cmp(int m);
    string p;
    int sz;
    p = m ? "dm1" : "dm0";
    sz = qsize(m);
    check({p, ".we"}, m ? int'(b.fifo_we) : int'(a.fifo_we), sz > 0);
    if (sz > 0) check({p, ".data"}, m ? int'(b.fifo_data) : int'(a.fifo_data), m ? q1[0] : q0[0]);
    check({p, ".ready"}, m ? int'(b.pix_ready) : int'(a.pix_ready), m == 1 || sz < 2);
    check({p, ".done"}, m ? int'(fd1) : int'(fd0), done[m]);
    check({p, ".err"}, m ? int'(fe1) : int'(fe0), err[m]);
    check({p, ".sync"}, m ? int'(sl1) : int'(sl0), st[m] == 2);
    check({p, ".drop"}, m ? int'(dc1) : int'(dc0), drop[m]);
  endtask
  task automatic tick();
    for (int m = 0; m < 2; m++) model(m);
    @(posedge w_clk);
    @(negedge w_clk);
    for (int m = 0; m < 2; m++) cmp(m);
    for (int m = 0; m < 2; m++)
      if (acc[m]) begin
        g[m] = ifs[m] ? 1 : (g[m] + 1) % N;
        iv[m] = 0;
      end
  endtask
  task automatic reset_checks();
    for (int m = 0; m < 2; m++) cmp(m);
    check("dm0.rst_data", int'(a.fifo_data), 0);
    check("dm1.rst_data", int'(b.fifo_data), 0);
  endtask
  task automatic do_reset();
    model_reset();
    for (int m = 0; m < 2; m++) ifull[m] = 0;
    reset = 1;
    @(negedge w_clk);
    reset_checks();
    reset = 0;
  endtask
  task automatic offer(bit fs, int d);
    for (int m = 0; m < 2; m++) begin
      iv[m] = 1; ifs[m] = fs; id[m] = W'(d); ifull[m] = 0;
    end
    tick();
  endtask
  task automatic run(int cyc, int pv, int pf, int pe);
    for (int c = 0; c < cyc; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!iv[m] && int'($urandom_range(99)) < pv) begin
          iv[m] = 1;
          ifs[m] = (g[m] == 0) ^ (int'($urandom_range(99)) < pe);
          id[m] = W'($urandom);
        end
        ifull[m] = int'($urandom_range(99)) < pf;
      end
      tick();
    end
  endtask
  initial begin
    for (int m = 0; m < 2; m++) begin
      ifs[m] = 0; id[m] = 0; ifull[m] = 0;
    end
    do_reset();
    for (int i = 0; i < 3; i++) offer(0, 7 + i);
    offer(1, 'h2A);
    for (int i = 0; i < 3; i++) offer(0, i + 1);
    do_reset();
    for (int i = 1; i <= 8; i++) offer(i == 1, i);
    offer(0, 9);
    for (int i = 0; i < 3; i++) offer(0, 10 + i);
    offer(1, 'h33);
    for (int i = 0; i < 4; i++) offer(0, 20 + i);
    run(200, 70, 20, 5);
    run(5, 100, 0, 0);
    run(10, 100, 100, 0);
    run(30, 100, 0, 0);
    run(25, 100, 100, 0);
    run(40, 100, 30, 0);
    run(3, 100, 100, 0);
    for (int m = 0; m < 2; m++) iv[m] = 0;
    #2 reset = 1;
    #1 model_reset();
    reset_checks();
    @(negedge w_clk);
    reset = 0;
    for (int m = 0; m < 2; m++) g[m] = 1;
    run(6, 100, 0, 0);
    run(300, 80, 25, 3);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
